uart_apb_sequencer: RTL and testbench

UART_APB_SEQUENCER -- requirements
Module: uart_apb_sequencer

---
 rtl/uart_apb_sequencer.sv | 131 +++++++++++++
 tb/tb_uart_apb_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: programs a 16550-style UART over APB, then arbitrates THR writes and RBR reads.
module uart_apb_sequencer #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_start,
  input  logic [7:0] cfg_ier,
  input  logic [7:0] cfg_fcr,
  input  logic [7:0] cfg_lcr,
  input  logic [7:0] cfg_dll,
  input  logic [7:0] cfg_dlh,
  output logic cfg_done,
  input  logic tx_valid,
  input  logic [7:0] tx_data,
  output logic tx_ready,
  input  logic rx_req,
  output logic rx_ack,
  output logic rx_valid,
  output logic [7:0] rx_data,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [31:0] pwdata,
  output logic pwrite,
  output logic psel,
  output logic penable,
  input  logic [31:0] prdata,
  input  logic pready,
  input  logic pslverr,
  output logic err
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {IDLE, CFG_SETUP, CFG_ACCESS, RUN, XF_SETUP, XF_ACCESS} state_t;
  state_t state;
  logic [2:0] idx;
  logic [WW-1:0] wait_cnt;
  logic prefer_rx;
  logic [7:0] fcr_q, lcr_q, dll_q, dlh_q;
  logic in_run, grant_tx, grant_rx, start, timeout, done, unused;

  function automatic logic [7:0] cfg_addr(input logic [2:0] i);
    return i == 3'd0 ? 8'h04 : i == 3'd1 ? 8'h08 : i == 3'd2 ? 8'h0C : i == 3'd3 ? 8'h10 :
           i == 3'd4 ? 8'h1C : i == 3'd5 ? 8'h20 : i == 3'd6 ? 8'h24 : 8'h28;
  endfunction

  // MCR, SCR and MDR are always written as zero
  function automatic logic [7:0] cfg_data(input logic [2:0] i);
    return i == 3'd1 ? fcr_q : i == 3'd2 ? lcr_q : i == 3'd5 ? dll_q : i == 3'd6 ? dlh_q : 8'h00;
  endfunction

  assign in_run = state == RUN;
  assign grant_tx = in_run && tx_valid && (!rx_req || !prefer_rx);
  assign grant_rx = in_run && rx_req && (!tx_valid || prefer_rx);
  assign tx_ready = grant_tx;
  assign rx_ack = grant_rx;
  assign start = cfg_start && (state == IDLE || (in_run && !grant_tx && !grant_rx));
  assign timeout = !pready && wait_cnt == WW'(WAIT_MAX - 1);
  assign done = pready || timeout;
  assign unused = ^prdata[31:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      wait_cnt <= '0;
      prefer_rx <= 1'b0;
      {fcr_q, lcr_q, dll_q, dlh_q} <= '0;
      {psel, penable, pwrite} <= '0;
      paddr <= '0;
      pwdata <= '0;
      cfg_done <= 1'b0;
      err <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (start) begin
        state <= CFG_SETUP;
        idx <= '0;
        wait_cnt <= '0;
        err <= 1'b0;
        cfg_done <= 1'b0;
        {fcr_q, lcr_q, dll_q, dlh_q} <= {cfg_fcr, cfg_lcr, cfg_dll, cfg_dlh};
        {psel, penable, pwrite} <= 3'b101;
        paddr <= APB_ADDR_WIDTH'(cfg_addr(3'd0));
        pwdata <= {24'h0, cfg_ier};
      end else begin
        case (state)
          CFG_SETUP: begin
            state <= CFG_ACCESS;
            penable <= 1'b1;
          end
          XF_SETUP: begin
            state <= XF_ACCESS;
            penable <= 1'b1;
          end
          CFG_ACCESS, XF_ACCESS: begin
            wait_cnt <= done ? '0 : wait_cnt + 1'b1;
            if (done) begin
              penable <= 1'b0;
              if (timeout || pslverr) err <= 1'b1;
              if (state == XF_ACCESS && !pwrite && pready) begin
                rx_valid <= 1'b1;
                rx_data <= prdata[7:0];
              end
              if (state == XF_ACCESS || idx == 3'd7) begin
                state <= RUN;
                psel <= 1'b0;
                cfg_done <= 1'b1;
              end else begin
                state <= CFG_SETUP;
                idx <= idx + 3'd1;
                paddr <= APB_ADDR_WIDTH'(cfg_addr(idx + 3'd1));
                pwdata <= {24'h0, cfg_data(idx + 3'd1)};
              end
            end
          end
          RUN: if (grant_tx || grant_rx) begin
            state <= XF_SETUP;
            psel <= 1'b1;
            pwrite <= grant_tx;
            paddr <= '0;
            pwdata <= grant_tx ? {24'h0, tx_data} : '0;
            prefer_rx <= grant_tx;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb_uart_apb_sequencer: directed checks of the config sequence, arbitration, waits, timeout and reset.
module tb_uart_apb_sequencer;
  localparam int WAIT_MAX = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_start, cfg_done, tx_valid, tx_ready, rx_req, rx_ack, rx_valid;
  logic [7:0] cfg_ier, cfg_fcr, cfg_lcr, cfg_dll, cfg_dlh, tx_data, rx_data;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic pwrite, psel, penable, pready, pslverr, err;
  int n_cmp = 0, n_fail = 0;

  typedef struct {
    bit is_tx;
    logic [7:0] tx_byte;
    logic [31:0] rdata;
    logic [31:0] exp_pwdata;
    logic [7:0] exp_rx;
  } xf_t;

  uart_apb_sequencer #(.APB_ADDR_WIDTH(12), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_ier(cfg_ier), .cfg_fcr(cfg_fcr), .cfg_lcr(cfg_lcr), .cfg_dll(cfg_dll), .cfg_dlh(cfg_dlh),
    .cfg_done(cfg_done), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_valid(rx_valid), .rx_data(rx_data),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE/RUN; returns at the first RUN cycle after the eighth write.
  task automatic do_cfg(input logic [7:0] ier, fcr, lcr, dll, dlh, input int wait_idx, input int wait_n,
                        input int err_idx, input bit hold_start, input bit exp_err);
    logic [11:0] ea [8];
    logic [7:0] ed [8];
    int n;
    ea = '{12'h004, 12'h008, 12'h00C, 12'h010, 12'h01C, 12'h020, 12'h024, 12'h028};
    ed = '{ier, fcr, lcr, 8'h00, 8'h00, dll, dlh, 8'h00};
    cfg_ier = ier; cfg_fcr = fcr; cfg_lcr = lcr; cfg_dll = dll; cfg_dlh = dlh;
    cfg_start = 1'b1;
    @(negedge clk);
    if (!hold_start) cfg_start = 1'b0;
    cfg_ier = 8'hAA; cfg_fcr = 8'hAA; cfg_lcr = 8'hAA; cfg_dll = 8'hAA; cfg_dlh = 8'hAA;
    chk("cfg_done_cleared", 32'(cfg_done), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) cfg_start = 1'b0;
      chk("setup_psel", 32'(psel), 32'd1);
      chk("setup_penable", 32'(penable), 32'd0);
      chk("setup_pwrite", 32'(pwrite), 32'd1);
      chk("setup_paddr", 32'(paddr), 32'(ea[k]));
      chk("setup_pwdata", pwdata, 32'(ed[k]));
      n = (k == wait_idx) ? wait_n : 0;
      for (int j = 0; j <= n; j++) begin
        @(negedge clk);
        pready = (j == n);
        pslverr = (j == n) && (k == err_idx);
        chk("access_penable", 32'(psel & penable), 32'd1);
        chk("access_paddr", 32'(paddr), 32'(ea[k]));
        chk("access_pwdata", pwdata, 32'(ed[k]));
        chk("access_cfg_done", 32'(cfg_done), 32'd0);
      end
      @(negedge clk);
    end
    pready = 1'b1;
    pslverr = 1'b0;
    chk("run_cfg_done", 32'(cfg_done), 32'd1);
    chk("run_psel", 32'(psel), 32'd0);
    chk("run_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    xf_t vec [4];
    logic [7:0] sb [3];
    vec[0] = '{1'b1, 8'h55, 32'h0000_0000, 32'h0000_0055, 8'h00};
    vec[1] = '{1'b0, 8'h11, 32'hDEAD_BE3C, 32'h0000_0000, 8'h3C};
    vec[2] = '{1'b1, 8'h00, 32'h0000_0000, 32'h0000_0000, 8'h00};
    vec[3] = '{1'b0, 8'h22, 32'h0000_00FF, 32'h0000_0000, 8'hFF};
    sb = '{8'h81, 8'hFF, 8'hF0};
    cfg_start = 0; cfg_ier = 0; cfg_fcr = 0; cfg_lcr = 0; cfg_dll = 0; cfg_dlh = 0;
    tx_valid = 0; tx_data = 0; rx_req = 0; prdata = 0; pready = 1; pslverr = 0;

    repeat (2) @(negedge clk);
    tx_valid = 1; rx_req = 1; cfg_start = 1;
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_grants", 32'({tx_ready, rx_ack}), 32'd0);
    tx_valid = 0; rx_req = 0; cfg_start = 0;
    rst = 0;
    @(negedge clk);
    tx_valid = 1;
    #1 chk("idle_tx_ready", 32'(tx_ready), 32'd0);
    tx_valid = 0;
    chk("idle_psel", 32'(psel), 32'd0);

    // plain configuration, cfg_start held during the sequence must be ignored
    do_cfg(8'h00, 8'h00, 8'h0B, 8'h0F, 8'h00, -1, 0, -1, 1'b1, 1'b0);
    @(negedge clk);
    chk("run_stays_run", 32'(psel), 32'd0);

    for (int i = 0; i < 4; i++) begin
      tx_valid = vec[i].is_tx; rx_req = !vec[i].is_tx;
      tx_data = vec[i].tx_byte; prdata = vec[i].rdata;
      #1;
      chk("vec_tx_ready", 32'(tx_ready), 32'(vec[i].is_tx));
      chk("vec_rx_ack", 32'(rx_ack), 32'(!vec[i].is_tx));
      @(negedge clk);
      tx_valid = 0; rx_req = 0; tx_data = 8'hEE;
      chk("vec_setup", 32'({psel, penable}), 32'd2);
      chk("vec_paddr", 32'(paddr), 32'd0);
      chk("vec_pwrite", 32'(pwrite), 32'(vec[i].is_tx));
      if (vec[i].is_tx) chk("vec_pwdata", pwdata, vec[i].exp_pwdata);
      @(negedge clk);
      tx_valid = 1; rx_req = 1;
      #1;
      chk("vec_access", 32'({psel, penable}), 32'd3);
      chk("vec_no_grant_busy", 32'({tx_ready, rx_ack}), 32'd0);
      tx_valid = 0; rx_req = 0;
      @(negedge clk);
      chk("vec_idle_psel", 32'(psel), 32'd0);
      chk("vec_rx_valid", 32'(rx_valid), 32'(!vec[i].is_tx));
      if (!vec[i].is_tx) chk("vec_rx_data", 32'(rx_data), 32'(vec[i].exp_rx));
      @(negedge clk);
      chk("vec_rx_valid_pulse", 32'(rx_valid), 32'd0);
    end

    // both requesting: round-robin starting with tx
    tx_valid = 1; rx_req = 1; tx_data = 8'h3C; prdata = 32'h0000_00A5;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("alt_tx_ready", 32'(tx_ready), 32'(g % 2 == 0));
      chk("alt_rx_ack", 32'(rx_ack), 32'(g % 2 == 1));
      @(negedge clk);
      chk("alt_pwrite", 32'(pwrite), 32'(g % 2 == 0));
      @(negedge clk);
      @(negedge clk);
      chk("alt_rx_valid", 32'(rx_valid), 32'(g % 2 == 1));
      if (g % 2 == 1) chk("alt_rx_data", 32'(rx_data), 32'h0000_00A5);
    end
    tx_valid = 0; rx_req = 0;
    @(negedge clk);

    // streaming tx: one THR write every 3 cycles
    tx_valid = 1; tx_data = sb[0];
    for (int i = 0; i < 3; i++) begin
      #1 chk("stream_ready", 32'(tx_ready), 32'd1);
      @(negedge clk);
      chk("stream_paddr", 32'(paddr), 32'd0);
      chk("stream_pwdata", pwdata, 32'(sb[i]));
      if (i == 2) tx_valid = 0; else tx_data = sb[i + 1];
      @(negedge clk);
      chk("stream_access", 32'(penable), 32'd1);
      @(negedge clk);
    end

    // read timeout: PREADY never arrives
    rx_req = 1; prdata = 32'h0000_0077;
    #1 chk("to_rx_ack", 32'(rx_ack), 32'd1);
    @(negedge clk);
    rx_req = 0; pready = 0;
    for (int i = 1; i <= WAIT_MAX; i++) begin
      @(negedge clk);
      chk("to_access_held", 32'({psel, penable}), 32'd3);
      chk("to_err_pending", 32'(err), 32'd0);
    end
    @(negedge clk);
    pready = 1;
    chk("to_psel_dropped", 32'({psel, penable}), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_no_rx_valid", 32'(rx_valid), 32'd0);
    @(negedge clk);
    chk("to_no_rx_valid2", 32'(rx_valid), 32'd0);

    // restart from RUN with a 3-cycle wait on the DLL write
    do_cfg(8'h01, 8'hC7, 8'h03, 8'h0F, 8'h00, 5, 3, -1, 1'b0, 1'b0);
    // PSLVERR on the FCR write
    do_cfg(8'h05, 8'h07, 8'h1B, 8'h36, 8'h01, -1, 0, 1, 1'b0, 1'b1);

    // reset in the middle of the LCR access
    cfg_lcr = 8'h03; cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_paddr", 32'(paddr), 32'h00C);
    chk("pre_rst_penable", 32'(penable), 32'd1);
    rst = 1;
    #1;
    chk("mid_rst_psel", 32'({psel, penable}), 32'd0);
    chk("mid_rst_paddr", 32'(paddr), 32'd0);
    chk("mid_rst_cfg_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_resume", 32'(psel), 32'd0);
    do_cfg(8'h0F, 8'h01, 8'h03, 8'h1A, 8'h00, -1, 0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
